// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and issues one word read at a
// time to instruction memory over a variable-latency req/ack handshake.
// Returned words are queued with their PC and handed to decode with
// valid/ready. Fetch stops on the all-zero word, and a redirect flushes the
// queue and restarts fetch at a new address.
//
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   imem_req_o         read request, held until imem_ack_i
//   imem_addr_o        word-aligned byte address of the request
//   imem_ack_i         memory returns imem_data_i this cycle
//   imem_data_i        returned instruction word
//   instr_o            head-of-queue instruction
//   instr_pc_o         byte address of instr_o
//   instr_valid_o      queue non-empty
//   instr_ready_i      decode takes the head this cycle
//   redirect_i         flush and restart fetch at redirect_pc_i
//   redirect_pc_i      restart address, low two bits ignored
//   pc_out_o           next address to be requested
//   halt_o             end-of-program word fetched
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_out_o,
    output logic        halt_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {RUN, WAIT, DROP, HALT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic push;
    logic pop;

    // A word is kept only when it answers the live request (not a dropped
    // one), is not the end-of-program marker, and no redirect is flushing.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (!redirect_i) begin
            push = (state == WAIT) && imem_ack_i && (imem_data_i != 32'd0);
            pop  = (count != '0) && instr_ready_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= RUN;
            pc          <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= 32'd0;
            halt_o      <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= 32'd0;
                q_pc[i]   <= 32'd0;
            end
        end else begin
            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= imem_data_i;
                    q_pc[wr_ptr]   <= imem_addr_o;
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end

            if (redirect_i) begin
                pc     <= {redirect_pc_i[31:2], 2'b00};
                halt_o <= 1'b0;
                unique case (state)
                    WAIT, DROP: begin
                        // An unanswered request must still complete; its
                        // data is thrown away from DROP.
                        if (imem_ack_i) begin
                            imem_req_o <= 1'b0;
                            state      <= RUN;
                        end else begin
                            state <= DROP;
                        end
                    end
                    RUN, HALT: begin
                        imem_req_o <= 1'b0;
                        state      <= RUN;
                    end
                endcase
            end else begin
                unique case (state)
                    RUN: begin
                        // count is the registered value, so a slot freed
                        // by this cycle's pop is only seen next cycle.
                        if (count < QFULL) begin
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= pc;
                            state       <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_ack_i) begin
                            imem_req_o <= 1'b0;
                            if (imem_data_i != 32'd0) begin
                                pc    <= pc + 32'd4;
                                state <= RUN;
                            end else begin
                                halt_o <= 1'b1;
                                state  <= HALT;
                            end
                        end
                    end
                    DROP: begin
                        if (imem_ack_i) begin
                            imem_req_o <= 1'b0;
                            state      <= RUN;
                        end
                    end
                    HALT: begin
                        imem_req_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign instr_o       = q_data[rd_ptr];
    assign instr_pc_o    = q_pc[rd_ptr];
    assign instr_valid_o = (count != '0);
    assign pc_out_o      = pc;

endmodule
